approx_mult_core: RTL and testbench
===================================

// Module: approx_mult_core
// PURPOSE
//  Downstream consumer of the operand window registers: takes two 8-bit leading-bit
//  windows (Y) plus their MSB addresses and forms an approximate 2*SIZE-bit product.
//  Serial shift-add 8x8 multiply, then one barrel-shift cycle realigns the product
//  to the original bit positions. start/busy/done handshake toward the main controller.
// PARAMETERS
//  SIZE        16  width of original operands held in the window registers
//  ADDRESSSIZE 4   width of MSB address (log2 SIZE)
//  WIN         8   window width (= SIZE/2); multiply iterations
// PORTS
//  clk      in   1             clock, rising edge
//  rst      in   1             reset, asynchronous, active-high
//  start    in   1             request; sampled only in IDLE
//  y_a      in   WIN           operand A window, y_a[WIN-1] = bit at addr_a
//  addr_a   in   ADDRESSSIZE   bit position of y_a[WIN-1] in original operand A
//  y_b      in   WIN           operand B window
//  addr_b   in   ADDRESSSIZE   bit position of y_b[WIN-1] in original operand B
//  busy     out  1             high from cycle after accepted start until done cycle inclusive
//  done     out  1             one-cycle pulse, product valid
//  product  out  2*SIZE        approximate product; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, product=0, internal acc/count/operand regs=0.
//  Operands unsigned. Effective address ea = (addr < WIN-1) ? WIN-1 : addr (clamp).
//  Shift amount sa = ea_a + ea_b - 2*(WIN-1); range 0..2*(SIZE-WIN) (0..16), 5 bits.
//  Result: product = ({y_a*y_b} zero-extended to 2*SIZE) << sa; no overflow possible.
//  FSM:
//   IDLE : done=0. start=1 -> latch y_a,y_b,sa; acc=0; cnt=0; -> MULT.
//   MULT : per cycle: if mplr[0] acc += mcand<<cnt (2*WIN-bit acc); mplr>>=1; cnt++;
//          after WIN cycles (cnt==WIN-1 on exit) -> SHIFT.
//   SHIFT: product <= acc << sa (single-cycle barrel) -> DONE.
//   DONE : done=1 for exactly this cycle -> IDLE.
//  Latency: start sampled at edge 0; done high in cycle 10 (1+8+1); fixed, data-independent.
//  busy = (state != IDLE). start while busy ignored, no queuing; start in the DONE
//   cycle ignored; start held high in IDLE after DONE launches a new operation.
//  Inputs only sampled on accepted start; later changes do not affect the result.
//  product register updates only in SHIFT; stays stable through MULT of next op? No:
//   product keeps prior value until SHIFT of next op overwrites it.
//  Zero window (y_a==0 or y_b==0) still takes full latency, product=0.
//  rst mid-operation: immediate return to IDLE, all outputs to reset values, no done.
// STRUCTURE
//  Package approx_mult_pkg: state enum {IDLE,MULT,SHIFT,DONE} (2-bit), WIN_DEFAULT,
//   sa width function / constant SA_W=5.
//  Sub-module serial_mult8: WIN-bit shift-add multiplier (load, step, acc out);
//   top keeps FSM, sa computation/clamp, barrel shift and product register.
// TESTING
//  1 y_a=FF,addr_a=15,y_b=FF,addr_b=15, start -> done at cycle 10, product=FE010000.
//  2 y_a=80,addr_a=7,y_b=01,addr_b=7 -> sa=0, product=00000080, busy high cycles 1..10.
//  3 clamp: y_a=0F,addr_a=3,y_b=03,addr_b=9 -> sa=2, product=000000B4.
//  4 y_a=00 any addr -> product=0 after full latency; done pulses exactly once.
//  5 new start + changed operands during MULT -> ignored; result from first op only.
//  6 rst asserted mid-MULT -> busy=0, done=0, product=0 same cycle; next start normal.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Purpose : shared types and constants for the approximate multiplier core.
// Latency : n/a (package).
// Backpressure: n/a (package).
package approx_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int SIZE_DEFAULT = 16;
    localparam int ADDR_DEFAULT = 4;
    localparam int WIN_DEFAULT  = 8;

    // Bits needed to hold a realignment shift of 0 .. 2*(size-win).
    function automatic int sa_width(input int size, input int win);
        return $clog2(2 * (size - win) + 1);
    endfunction

    localparam int SA_W = sa_width(SIZE_DEFAULT, WIN_DEFAULT);

endpackage

// File: rtl/approx_mult_core_if.sv
// Purpose : request/response bundle between the main controller and the multiplier core.
// Latency : n/a (wiring only).
// Backpressure: start is ignored while busy; the controller waits for done.
// Signals : start, y_a/addr_a, y_b/addr_b (controller -> core); busy, done, product (core -> controller).
interface approx_mult_core_if #(
    parameter int SIZE        = 16,
    parameter int ADDRESSSIZE = 4,
    parameter int WIN         = 8
);
    logic                   start;
    logic [WIN-1:0]         y_a;
    logic [ADDRESSSIZE-1:0] addr_a;
    logic [WIN-1:0]         y_b;
    logic [ADDRESSSIZE-1:0] addr_b;
    logic                   busy;
    logic                   done;
    logic [2*SIZE-1:0]      product;

    modport master (
        output start, y_a, addr_a, y_b, addr_b,
        input  busy, done, product
    );

    modport slave (
        input  start, y_a, addr_a, y_b, addr_b,
        output busy, done, product
    );
endinterface

// File: rtl/approx_mult_core_mult.sv
// Purpose : WIN x WIN unsigned shift-add multiplier, one multiplier bit per i_step.
// Latency : WIN steps after i_load; o_last is high during the final step.
// Backpressure: none; the caller decides when to step.
// Ports   : clk, rst, i_load, i_step, i_mcand, i_mplr -> o_acc (2*WIN), o_last.
module serial_mult8 #(
    parameter int WIN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIN-1:0]   i_mcand,
    input  logic [WIN-1:0]   i_mplr,
    output logic [2*WIN-1:0] o_acc,
    output logic             o_last
);
    localparam int CW = $clog2(WIN);

    logic [WIN-1:0]   r_mcand;
    logic [WIN-1:0]   r_mplr;
    logic [2*WIN-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    wire w_last = (r_cnt == CW'(WIN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_mcand <= i_mcand;
            r_mplr  <= i_mplr;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (i_step) begin
            if (r_mplr[0])
                r_acc <= r_acc + ((2*WIN)'(r_mcand) << r_cnt);
            r_mplr <= r_mplr >> 1;
            // Counter parks on WIN-1 so the exit step still sees o_last.
            if (!w_last)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_acc  = r_acc;
    assign o_last = w_last;
endmodule

// File: rtl/approx_mult_core.sv
// Purpose : approximate product of two leading-bit windows, realigned to original bit positions.
// Latency : start accepted at edge 0, done pulses in cycle 10 (1 load + WIN mult + 1 shift), fixed.
// Backpressure: start ignored while busy (including the done cycle); no queuing.
// Ports   : clk, rst (async, active-high), bus (slave): start, y_a, addr_a, y_b, addr_b in;
//           busy, done, product out. product holds until the next operation's shift cycle.
module approx_mult_core
    import approx_mult_pkg::*;
#(
    parameter int SIZE        = 16,
    parameter int ADDRESSSIZE = 4,
    parameter int WIN         = 8
) (
    input logic               clk,
    input logic               rst,
    approx_mult_core_if.slave bus
);
    localparam int SAW = sa_width(SIZE, WIN);
    localparam int PW  = 2 * SIZE;
    localparam logic [ADDRESSSIZE-1:0] EA_MIN = ADDRESSSIZE'(WIN - 1);

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [PW-1:0]   r_product;
    logic [SAW-1:0]  r_sa;

    logic [2*WIN-1:0] w_acc;
    logic             w_last;

    wire w_accept = (r_state == S_IDLE) && bus.start;
    wire w_step   = (r_state == S_MULT);

    // Windows taken from below bit WIN-1 are already in place; clamp so they need no shift.
    wire [ADDRESSSIZE-1:0] w_ea_a = (bus.addr_a < EA_MIN) ? EA_MIN : bus.addr_a;
    wire [ADDRESSSIZE-1:0] w_ea_b = (bus.addr_b < EA_MIN) ? EA_MIN : bus.addr_b;
    wire [SAW-1:0]         w_sa   = SAW'(w_ea_a) + SAW'(w_ea_b) - SAW'(2 * (WIN - 1));

    wire [PW-1:0] w_shifted = PW'(w_acc) << r_sa;

    serial_mult8 #(.WIN(WIN)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_step  (w_step),
        .i_mcand (bus.y_a),
        .i_mplr  (bus.y_b),
        .o_acc   (w_acc),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_sa      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sa    <= w_sa;
                        r_busy  <= 1'b1;
                        r_state <= S_MULT;
                    end
                end
                S_MULT: begin
                    if (w_last)
                        r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_product <= w_shifted;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_approx_mult_core.sv
module tb_approx_mult_core;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    logic [31:0] prev_product;

    approx_mult_core_if #(.SIZE(16), .ADDRESSSIZE(4), .WIN(8)) bus ();

    approx_mult_core #(.SIZE(16), .ADDRESSSIZE(4), .WIN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: clamp each MSB address to at least 7, multiply, shift by the address excess.
    function automatic logic [31:0] model(input int ya, input int aa, input int yb, input int ab);
        int ea_a;
        int ea_b;
        logic [31:0] p;
        ea_a = (aa < 7) ? 7 : aa;
        ea_b = (ab < 7) ? 7 : ab;
        p = 32'(ya * yb);
        return p << (ea_a + ea_b - 14);
    endfunction

    task automatic drive(input logic [7:0] ya, input logic [3:0] aa,
                         input logic [7:0] yb, input logic [3:0] ab);
        bus.y_a = ya; bus.addr_a = aa; bus.y_b = yb; bus.addr_b = ab;
    endtask

    // One operation: start sampled at edge 0, then cycles 1..12 observed at the falling edge.
    task automatic run_op(input string name, input logic [7:0] ya, input logic [3:0] aa,
                          input logic [7:0] yb, input logic [3:0] ab, input logic [31:0] exp);
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        drive(ya, aa, yb, ab);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drive(8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom));
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
            n_total++;
            if (bus.busy !== (k <= 10)) $display("FAIL %s busy cycle %0d: got %b want %b", name, k, bus.busy, (k <= 10));
            else n_pass++;
            n_total++;
            if (bus.done !== (k == 10)) $display("FAIL %s done cycle %0d: got %b want %b", name, k, bus.done, (k == 10));
            else n_pass++;
            if (k < 10) begin
                n_total++;
                if (bus.product !== prev_product) $display("FAIL %s product hold cycle %0d: got %h want %h", name, k, bus.product, prev_product);
                else n_pass++;
            end else begin
                n_total++;
                if (bus.product !== exp) $display("FAIL %s product cycle %0d: got %h want %h", name, k, bus.product, exp);
                else n_pass++;
            end
        end
        n_total++;
        if (done_cnt != 1) $display("FAIL %s done pulses: got %0d want 1", name, done_cnt);
        else n_pass++;
        prev_product = exp;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        drive(8'h00, 4'h0, 8'h00, 4'h0);
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset busy/done: got %b want 00", {bus.busy, bus.done});
        else n_pass++;
        n_total++;
        if (bus.product !== 32'h0) $display("FAIL reset product: got %h want 00000000", bus.product);
        else n_pass++;
        rst = 1'b0;
        prev_product = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op("ff_x_ff",  8'hFF, 4'd15, 8'hFF, 4'd15, 32'hFE010000);
        run_op("80_x_01",  8'h80, 4'd7,  8'h01, 4'd7,  32'h00000080);
        run_op("clamp",    8'h0F, 4'd3,  8'h03, 4'd9,  32'h000000B4);
        run_op("zero_win", 8'h00, 4'd12, 8'hC3, 4'd14, 32'h00000000);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ya, yb;
            logic [3:0] aa, ab;
            ya = 8'($urandom);
            yb = 8'($urandom);
            aa = 4'($urandom_range(0, 15));
            ab = 4'($urandom_range(0, 15));
            run_op("random", ya, aa, yb, ab, model(int'(ya), int'(aa), int'(yb), int'(ab)));
        end
    endtask

    // Restart attempts mid-MULT and in the done cycle must be dropped.
    task automatic test_ignore_start();
        logic [31:0] exp;
        exp = model(8'hA7, 11, 8'h5D, 9);
        @(negedge clk);
        drive(8'hA7, 4'd11, 8'h5D, 4'd9);
        bus.start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            bus.start = (k == 3) || (k == 10);
            if (k == 3) drive(8'h11, 4'd15, 8'hEE, 4'd15);
            if (k == 10) begin
                n_total++;
                if (bus.product !== exp) $display("FAIL ignore_start product: got %h want %h", bus.product, exp);
                else n_pass++;
            end
            if (k >= 11) begin
                n_total++;
                if (bus.busy !== 1'b0) $display("FAIL ignore_start busy cycle %0d: got %b want 0", k, bus.busy);
                else n_pass++;
            end
        end
        bus.start = 1'b0;
        prev_product = exp;
    endtask

    // start held high: second op launches from IDLE right after DONE with operands seen then.
    task automatic test_back_to_back();
        logic [31:0] exp_a, exp_b;
        exp_a = model(8'hC9, 13, 8'h77, 10);
        exp_b = model(8'h3B, 2, 8'hF1, 15);
        @(negedge clk);
        drive(8'hC9, 4'd13, 8'h77, 4'd10);
        bus.start = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 5) drive(8'h3B, 4'd2, 8'hF1, 4'd15);
            if (k == 12) bus.start = 1'b0;
            if (k == 10 || k == 20) begin
                n_total++;
                if (bus.product !== exp_a) $display("FAIL b2b first product cycle %0d: got %h want %h", k, bus.product, exp_a);
                else n_pass++;
            end
            if (k == 11 || k == 12 || k == 21) begin
                n_total++;
                if (bus.busy !== (k == 12 || k == 21)) $display("FAIL b2b busy cycle %0d: got %b want %b", k, bus.busy, (k == 12 || k == 21));
                else n_pass++;
            end
            if (k == 21) begin
                n_total++;
                if (bus.done !== 1'b1) $display("FAIL b2b second done: got %b want 1", bus.done);
                else n_pass++;
                n_total++;
                if (bus.product !== exp_b) $display("FAIL b2b second product: got %h want %h", bus.product, exp_b);
                else n_pass++;
            end
        end
        prev_product = exp_b;
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        drive(8'hE5, 4'd14, 8'h9A, 4'd12);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_total++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_mid busy/done: got %b want 00", {bus.busy, bus.done});
        else n_pass++;
        n_total++;
        if (bus.product !== 32'h0) $display("FAIL reset_mid product: got %h want 00000000", bus.product);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        n_total++;
        if (done_seen != 0) $display("FAIL reset_mid stray activity: got %0d cycles want 0", done_seen);
        else n_pass++;
        prev_product = 32'h0;
        run_op("after_reset", 8'h9B, 4'd10, 8'h46, 4'd5, model(8'h9B, 10, 8'h46, 5));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        prev_product = 32'h0;
        rst = 1'b1;
        bus.start = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
